// File: rtl/blob_box_builder_pkg.sv
// Shared definitions for the blob box builder and the box-overlay drawer.
// Holds the packed box layout, the FSM states and the pack/unpack helpers.
package blob_box_builder_pkg;

    localparam int COORD_W = 10;
    localparam int BOX_W   = 40;
    localparam int X0_LSB  = 0;
    localparam int Y0_LSB  = 10;
    localparam int XN_LSB  = 20;
    localparam int YN_LSB  = 30;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] yn;
        logic [COORD_W-1:0] xn;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x0;
    } box_t;

    function automatic logic [BOX_W-1:0] pack_box(input box_t b);
        logic [BOX_W-1:0] v;
        v = {BOX_W{1'b0}};
        v[X0_LSB +: COORD_W] = b.x0;
        v[Y0_LSB +: COORD_W] = b.y0;
        v[XN_LSB +: COORD_W] = b.xn;
        v[YN_LSB +: COORD_W] = b.yn;
        return v;
    endfunction

    function automatic box_t unpack_box(input logic [BOX_W-1:0] v);
        box_t b;
        b.x0 = v[X0_LSB +: COORD_W];
        b.y0 = v[Y0_LSB +: COORD_W];
        b.xn = v[XN_LSB +: COORD_W];
        b.yn = v[YN_LSB +: COORD_W];
        return b;
    endfunction

endpackage

// File: rtl/blob_box_match.sv
// Combinational adjacency test of one pixel against one box slot.
// Limits are formed in 11 bits and saturated to the 0..1023 coordinate range.
module blob_box_match
    import blob_box_builder_pkg::*;
#(
    parameter int GAP = 2
) (
    input  logic               valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  box_t               box,
    output logic               hit
);
    localparam logic [COORD_W:0] GAP_EXT   = (COORD_W+1)'(GAP);
    localparam logic [COORD_W:0] COORD_MAX = (COORD_W+1)'((1 << COORD_W) - 1);

    logic [COORD_W:0] x_lo_s;
    logic [COORD_W:0] x_hi_raw_s;
    logic [COORD_W:0] x_hi_s;
    logic [COORD_W:0] y_hi_raw_s;
    logic [COORD_W:0] y_hi_s;

    // Saturated window limits around the box
    always_comb begin
        x_lo_s     = {(COORD_W+1){1'b0}};
        x_hi_raw_s = {1'b0, box.xn} + GAP_EXT;
        y_hi_raw_s = {1'b0, box.yn} + GAP_EXT;
        if ({1'b0, box.x0} >= GAP_EXT) begin
            x_lo_s = {1'b0, box.x0} - GAP_EXT;
        end else begin
            x_lo_s = {(COORD_W+1){1'b0}};
        end
        if (x_hi_raw_s > COORD_MAX) begin
            x_hi_s = COORD_MAX;
        end else begin
            x_hi_s = x_hi_raw_s;
        end
        if (y_hi_raw_s > COORD_MAX) begin
            y_hi_s = COORD_MAX;
        end else begin
            y_hi_s = y_hi_raw_s;
        end
    end

    // Raster order guarantees y >= y0, so only the lower-right bound on y is checked
    assign hit = valid
               && ({1'b0, x} >= x_lo_s)
               && ({1'b0, x} <= x_hi_s)
               && ({1'b0, y} <= y_hi_s);

endmodule

// File: rtl/blob_box_builder.sv
// Grows one bounding box per foreground blob per frame, then dumps the table.
// Build option BLOB_BOX_MIN_SIZE_EN drops boxes smaller than MIN_W x MIN_H at dump.
module blob_box_builder
    import blob_box_builder_pkg::*;
#(
    parameter int MAX_BLOBS = 21,
    parameter int GAP       = 2,
    parameter int MIN_W     = 3,
    parameter int MIN_H     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_pix,
    input  logic               fg,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_end,
    output logic [BOX_W-1:0]   xy,
    output logic [7:0]         bl_addr,
    output logic               bl_en,
    output logic [7:0]         bl_cnt,
    output logic               busy,
    output logic               overflow
);
    localparam int CNT_W  = 8;
    localparam int SLOT_W = (MAX_BLOBS > 1) ? $clog2(MAX_BLOBS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BLOBS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

`ifdef BLOB_BOX_MIN_SIZE_EN
    localparam bit SIZE_FILTER = 1'b1;
`else
    localparam bit SIZE_FILTER = 1'b0;
`endif

    function automatic logic box_size_ok(input box_t b);
        logic [COORD_W:0] w;
        logic [COORD_W:0] h;
        w = {1'b0, b.xn} - {1'b0, b.x0} + {{COORD_W{1'b0}}, 1'b1};
        h = {1'b0, b.yn} - {1'b0, b.y0} + {{COORD_W{1'b0}}, 1'b1};
        return (w >= (COORD_W+1)'(MIN_W)) && (h >= (COORD_W+1)'(MIN_H));
    endfunction

    state_t               state_r, state_nxt_s;
    box_t                 box_r [MAX_BLOBS];
    box_t                 box_nxt_s [MAX_BLOBS];
    logic [MAX_BLOBS-1:0] valid_r, valid_nxt_s;
    logic [CNT_W-1:0]     count_r, count_nxt_s;
    logic                 overflow_r, ovf_nxt_s;
    logic [CNT_W-1:0]     dump_idx_r, dump_idx_nxt_s;
    logic [CNT_W-1:0]     emit_cnt_r, emit_cnt_nxt_s;
    logic [BOX_W-1:0]     xy_r, xy_nxt_s;
    logic [7:0]           bl_addr_r, bl_addr_nxt_s;
    logic                 bl_en_r, bl_en_nxt_s;
    logic [7:0]           bl_cnt_r, bl_cnt_nxt_s;
    logic                 busy_r;

    logic [MAX_BLOBS-1:0] hit_s;
    logic                 match_any_s;
    logic [SLOT_W-1:0]    match_idx_s;
    logic [SLOT_W-1:0]    alloc_slot_s;
    logic                 pix_take_s;
    logic [SLOT_W-1:0]    emit_sel_s;
    box_t                 emit_box_s;
    logic                 emit_ok_s;
    logic                 emit_try_s;

    assign pix_take_s = (state_r == ACCUM) && new_pix && fg;

    for (genvar gi = 0; gi < MAX_BLOBS; gi++) begin : g_match
        blob_box_match #(.GAP(GAP)) u_match (
            .valid (valid_r[gi]),
            .x     (x),
            .y     (y),
            .box   (box_r[gi]),
            .hit   (hit_s[gi])
        );
    end

    // Lowest-index matching slot wins
    always_comb begin
        match_any_s = |hit_s;
        match_idx_s = {SLOT_W{1'b0}};
        for (int i = MAX_BLOBS - 1; i >= 0; i--) begin
            match_idx_s = hit_s[i] ? SLOT_W'(i) : match_idx_s;
        end
    end

    // Next box table: grow, allocate, flag overflow, or wipe in CLEAR
    always_comb begin
        box_nxt_s    = box_r;
        valid_nxt_s  = valid_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = overflow_r;
        alloc_slot_s = count_r[SLOT_W-1:0];
        if (state_r == CLEAR) begin
            valid_nxt_s = {MAX_BLOBS{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else if (pix_take_s && match_any_s) begin
            box_nxt_s[match_idx_s].x0 = (x < box_r[match_idx_s].x0) ? x : box_r[match_idx_s].x0;
            box_nxt_s[match_idx_s].xn = (x > box_r[match_idx_s].xn) ? x : box_r[match_idx_s].xn;
            box_nxt_s[match_idx_s].yn = (y > box_r[match_idx_s].yn) ? y : box_r[match_idx_s].yn;
        end else if (pix_take_s && (count_r < MAX_CNT)) begin
            box_nxt_s[alloc_slot_s]   = '{yn: y, xn: x, y0: y, x0: x};
            valid_nxt_s[alloc_slot_s] = 1'b1;
            count_nxt_s               = count_r + ONE_CNT;
        end else if (pix_take_s) begin
            ovf_nxt_s = 1'b0 | 1'b1;
        end else begin
            ovf_nxt_s = overflow_r;
        end
    end

    // The first slot is emitted on the frame_end edge, so it reads the updated table
    assign emit_sel_s = (state_r == ACCUM) ? {SLOT_W{1'b0}} : dump_idx_r[SLOT_W-1:0];
    assign emit_box_s = box_nxt_s[emit_sel_s];
    assign emit_ok_s  = SIZE_FILTER ? box_size_ok(emit_box_s) : 1'b1;

    // FSM next state and next values of the registered write port
    always_comb begin
        state_nxt_s    = state_r;
        dump_idx_nxt_s = dump_idx_r;
        emit_cnt_nxt_s = emit_cnt_r;
        bl_en_nxt_s    = 1'b0;
        bl_addr_nxt_s  = bl_addr_r;
        xy_nxt_s       = xy_r;
        bl_cnt_nxt_s   = bl_cnt_r;
        emit_try_s     = 1'b0;
        case (state_r)
            ACCUM: begin
                if (frame_end && (count_nxt_s == {CNT_W{1'b0}})) begin
                    state_nxt_s  = CLEAR;
                    bl_cnt_nxt_s = 8'd0;
                end else if (frame_end) begin
                    state_nxt_s    = DUMP;
                    dump_idx_nxt_s = ONE_CNT;
                    emit_try_s     = 1'b1;
                    if (!SIZE_FILTER) begin
                        bl_cnt_nxt_s = count_nxt_s;
                    end else begin
                        bl_cnt_nxt_s = bl_cnt_r;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DUMP: begin
                if (dump_idx_r < count_r) begin
                    emit_try_s     = 1'b1;
                    dump_idx_nxt_s = dump_idx_r + ONE_CNT;
                end else begin
                    state_nxt_s = CLEAR;
                    if (SIZE_FILTER) begin
                        bl_cnt_nxt_s = emit_cnt_r;
                    end else begin
                        bl_cnt_nxt_s = bl_cnt_r;
                    end
                end
            end
            CLEAR: begin
                state_nxt_s    = ACCUM;
                dump_idx_nxt_s = {CNT_W{1'b0}};
                emit_cnt_nxt_s = {CNT_W{1'b0}};
            end
            default: begin
                state_nxt_s    = ACCUM;
                dump_idx_nxt_s = {CNT_W{1'b0}};
                emit_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
        if (emit_try_s && emit_ok_s) begin
            bl_en_nxt_s    = 1'b1;
            bl_addr_nxt_s  = emit_cnt_r;
            xy_nxt_s       = pack_box(emit_box_s);
            emit_cnt_nxt_s = emit_cnt_r + ONE_CNT;
        end else begin
            bl_en_nxt_s = 1'b0;
        end
    end

    // Box table storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_BLOBS; i++) begin
                box_r[i] <= '{yn: 10'd0, xn: 10'd0, y0: 10'd0, x0: 10'd0};
            end
            valid_r    <= {MAX_BLOBS{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            box_r      <= box_nxt_s;
            valid_r    <= valid_nxt_s;
            count_r    <= count_nxt_s;
            overflow_r <= ovf_nxt_s;
        end
    end

    // FSM state, dump pointers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ACCUM;
            dump_idx_r <= {CNT_W{1'b0}};
            emit_cnt_r <= {CNT_W{1'b0}};
            xy_r       <= {BOX_W{1'b0}};
            bl_addr_r  <= 8'd0;
            bl_en_r    <= 1'b0;
            bl_cnt_r   <= 8'd0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dump_idx_r <= dump_idx_nxt_s;
            emit_cnt_r <= emit_cnt_nxt_s;
            xy_r       <= xy_nxt_s;
            bl_addr_r  <= bl_addr_nxt_s;
            bl_en_r    <= bl_en_nxt_s;
            bl_cnt_r   <= bl_cnt_nxt_s;
            busy_r     <= (state_nxt_s != ACCUM);
        end
    end

    assign xy       = xy_r;
    assign bl_addr  = bl_addr_r;
    assign bl_en    = bl_en_r;
    assign bl_cnt   = bl_cnt_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule
